// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares a single synchronous FIFO write port among
// N_REQ valid/ready requesters. One requester owns the port at a time, for at
// most MAX_BURST accepted beats, and ownership then rotates past it. The FIFO
// full flag gates every write, so no write is ever issued while full.
//
// Handshake: a beat moves from requester i to the FIFO in a cycle where
// req_valid[i] and req_ready[i] are both high. Valid may drop at any time, but
// dropping it while owning the port gives up the grant. Data need only be
// stable in the cycle its ready is high.
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous, active-low reset
//   req_valid      per-requester data valid
//   req_data       packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ready      per-requester accept, zero or one-hot
//   fifo_full      FIFO full flag
//   fifo_write_en  FIFO write enable (combinational from the transfer)
//   fifo_data_in   FIFO write data (owner's slice while owning, else 0)
//   grant_active   high while a requester owns the port (state OWN)
//   grant_id       index of the current or last owner
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 8,
    parameter  int MAX_BURST = 4,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_write_en,
    output logic [DATA_W-1:0]       fifo_data_in,
    output logic                    grant_active,
    output logic [ID_W-1:0]         grant_id
);

    localparam int BEAT_W = $clog2(MAX_BURST) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    // Elaboration-time guard on parameter ranges.
    generate
        if (N_REQ < 2 || N_REQ > 8 || (N_REQ & (N_REQ - 1)) != 0) begin : g_bad_nreq
            $error("fifo_wr_arbiter: N_REQ must be a power of two in 2..8");
        end
        if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
            $error("fifo_wr_arbiter: MAX_BURST must be in 1..16");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t              state, state_d;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_d;
    logic [BEAT_W-1:0]   beat_cnt, beat_cnt_d;

    logic [ID_W-1:0]     pick;
    logic [ID_W-1:0]     cand;
    logic                owner_valid;
    logic [DATA_W-1:0]   owner_data;
    logic                own;
    logic                transfer;

    // -------------------------------------------------------------------------
    // Round-robin pick: first set req_valid bit at rr_ptr, rr_ptr+1, ...
    // Scanning offsets from high to low lets the lowest offset win. ID_W-bit
    // arithmetic wraps modulo N_REQ because N_REQ is a power of two.
    // -------------------------------------------------------------------------
    always_comb begin
        pick = rr_ptr;
        cand = rr_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = rr_ptr + ID_W'(k);
            if (req_valid[cand]) begin
                pick = cand;
            end
        end
    end

    // Owner's valid and data slice, selected by the registered grant_id.
    always_comb begin
        owner_data  = '0;
        owner_valid = req_valid[grant_id];
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                owner_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign own      = (state == OWN);
    assign transfer = own & owner_valid & ~fifo_full;

    // -------------------------------------------------------------------------
    // Outputs. Everything is decoded from registered state, so the
    // asynchronous reset clears write enable and ready immediately.
    // Ready is offered to the owner whenever the FIFO has room, independent of
    // its valid, so ready never depends combinationally on the same valid.
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        if (own && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign fifo_write_en = transfer;
    assign fifo_data_in  = own ? owner_data : '0;
    assign grant_active  = own;

    // -------------------------------------------------------------------------
    // Next-state logic.
    // IDLE: register the pick; no transfer happens in this cycle, which is the
    //       one-cycle bubble between grants.
    // OWN : count accepted beats; a full-stall cycle neither transfers nor
    //       counts. Release on the last beat of a burst, or at once (without a
    //       transfer) when the owner drops valid.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        grant_id_d = grant_id;
        beat_cnt_d = beat_cnt;

        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_id_d = pick;
                    beat_cnt_d = '0;
                    state_d    = OWN;
                end
            end

            OWN: begin
                if (!owner_valid) begin
                    rr_ptr_d   = grant_id + ID_W'(1);
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end else if (transfer) begin
                    if (beat_cnt == LAST_BEAT) begin
                        rr_ptr_d   = grant_id + ID_W'(1);
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt + BEAT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            grant_id <= grant_id_d;
            beat_cnt <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed tests push hand-computed write beats {cycle stamp, owner id, data}
// into exp_q before stimulus runs; a monitor on the falling edge pops and
// compares each FIFO write as it appears, and also checks port-level
// invariants every cycle. A short random phase exercises the invariants and
// the fairness bound only.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int W  = 16 + IW + DW;

    // ------------------------------------------------------------ clock/reset
    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_write_en;
    logic [DW-1:0]   fifo_data_in;
    logic            grant_active;
    logic [IW-1:0]   grant_id;

    always #5 clk = ~clk;

    logic [15:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 16'd1;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_write_en(fifo_write_en),
        .fifo_data_in (fifo_data_in),
        .grant_active (grant_active),
        .grant_id     (grant_id)
    );

    // ------------------------------------------------------------ scoreboard
    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    bit           rand_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int stamp, input int id, input int data);
        logic [15:0]   s;
        logic [IW-1:0] g;
        logic [DW-1:0] d;
        s = stamp[15:0];
        g = id[IW-1:0];
        d = data[DW-1:0];
        exp_q.push_back({s, g, d});
    endtask

    // ------------------------------------------------------------ source model
    logic [7:0] src_mem[N][16];
    int         src_len[N];
    int         src_pos[N];

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (src_pos[i] < src_len[i]);
            req_data[i*DW +: DW] = req_valid[i] ? src_mem[i][src_pos[i]] : 8'h00;
        end
    endtask

    task automatic load(input int i, input int first, input int n);
        src_len[i] = n;
        src_pos[i] = 0;
        for (int k = 0; k < n; k++) src_mem[i][k] = 8'(first + k);
    endtask

    // One clock: note accepted beats before the edge, advance sources after.
    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) src_pos[i]++;
        apply();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        apply();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // ------------------------------------------------------------ monitor
    initial begin
        logic [N-1:0] snap;
        bit           arb_seen;
        bit           prev_ga;
        int           wait_cnt[N];
        logic [W-1:0] got, exp;
        logic [N-1:0] want_ready;
        arb_seen = 1'b0;
        prev_ga  = 1'b0;
        snap     = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        forever begin
            @(negedge clk);
            check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (fifo_write_en) begin
                check("no_write_while_full", 32'(fifo_full), 32'd0);
                check("wr_data_is_owner_slice", 32'(fifo_data_in), 32'(req_data[grant_id*DW +: DW]));
                if (!rand_mode) begin
                    got = {cyc, grant_id, fifo_data_in};
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: got {cyc,id,data}=0x%0h, expected no write", got);
                    end else begin
                        exp = exp_q.pop_front();
                        check("wr_beat{cyc,id,data}", 32'(got), 32'(exp));
                    end
                end
            end
            if (!reset_n) begin
                check("reset_no_ready", 32'(req_ready), 32'd0);
                arb_seen = 1'b0;
                prev_ga  = 1'b0;
                for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            end else begin
                want_ready = '0;
                if (grant_active && !fifo_full) want_ready[grant_id] = 1'b1;
                check("ready_vs_owner_full", 32'(req_ready), 32'(want_ready));
                if (!grant_active && |req_valid) begin
                    snap     = req_valid;
                    arb_seen = 1'b1;
                end else if (grant_active && !prev_ga && arb_seen) begin
                    check("winner_was_valid", 32'(snap[grant_id]), 32'd1);
                    for (int i = 0; i < N; i++) begin
                        if (i == int'(grant_id)) wait_cnt[i] = 0;
                        else if (snap[i])        wait_cnt[i]++;
                        else                     wait_cnt[i] = 0;
                        if (snap[i]) check("starvation_bound", 32'(wait_cnt[i] <= N - 1), 32'd1);
                    end
                    arb_seen = 1'b0;
                end
                prev_ga = grant_active;
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int base;
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_write_en", 32'(fifo_write_en), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant_active", 32'(grant_active), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_data_in", 32'(fifo_data_in), 32'd0);

        // T1: requester 0 alone, 0x11..0x18: two bursts of 4, one bubble.
        do_reset();
        load(0, 'h11, 8);
        apply();
        base = int'(cyc);
        for (int k = 0; k < 4; k++) push_exp(base + 1 + k, 0, 'h11 + k);
        for (int k = 0; k < 4; k++) push_exp(base + 6 + k, 0, 'h15 + k);
        #1;
        check("t1_idle_first", 32'(grant_active), 32'd0);
        tick();
        check("t1_grant_active", 32'(grant_active), 32'd1);
        check("t1_grant_id", 32'(grant_id), 32'd0);
        repeat (4) tick();
        check("t1_bubble", 32'(grant_active), 32'd0);
        repeat (6) tick();
        check("t1_drained", 32'(exp_q.size()), 32'd0);
        check("t1_idle_end", 32'(grant_active), 32'd0);

        // T2: all four valid: order 0,1,2,3,0, 4 beats each, one bubble between.
        do_reset();
        load(0, 'h00, 8);
        load(1, 'h10, 4);
        load(2, 'h20, 4);
        load(3, 'h30, 4);
        apply();
        base = int'(cyc);
        for (int g = 0; g < 5; g++)
            for (int k = 0; k < 4; k++)
                push_exp(base + 1 + 5 * g + k, g % 4, 16 * (g % 4) + (g == 4 ? 4 : 0) + k);
        tick();
        check("t2_grant0", 32'(grant_id), 32'd0);
        for (int g = 1; g < 5; g++) begin
            repeat (4) tick();
            check("t2_bubble", 32'(grant_active), 32'd0);
            tick();
            check("t2_grant_order", 32'(grant_id), 32'(g % 4));
        end
        repeat (5) tick();
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // T3: requester 2, FIFO full for 5 cycles after beat 2.
        do_reset();
        load(2, 'h21, 6);
        apply();
        base = int'(cyc);
        push_exp(base + 1, 2, 'h21);
        push_exp(base + 2, 2, 'h22);
        push_exp(base + 8, 2, 'h23);
        push_exp(base + 9, 2, 'h24);
        push_exp(base + 11, 2, 'h25);
        push_exp(base + 12, 2, 'h26);
        repeat (3) tick();
        fifo_full = 1'b1;
        #1;
        check("t3_stall_ready", 32'(req_ready), 32'd0);
        check("t3_stall_write_en", 32'(fifo_write_en), 32'd0);
        check("t3_stall_grant_id", 32'(grant_id), 32'd2);
        repeat (4) begin
            tick();
            check("t3_stall_hold_active", 32'(grant_active), 32'd1);
            check("t3_stall_hold_id", 32'(grant_id), 32'd2);
        end
        tick();
        fifo_full = 1'b0;
        repeat (2) tick();
        check("t3_release_after_4", 32'(grant_active), 32'd0);
        repeat (4) tick();
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_idle_end", 32'(grant_active), 32'd0);

        // T4: requester 1 drops valid after 2 beats; requester 3 waiting.
        do_reset();
        load(1, 'h41, 2);
        load(3, 'h61, 4);
        apply();
        base = int'(cyc);
        push_exp(base + 1, 1, 'h41);
        push_exp(base + 2, 1, 'h42);
        for (int k = 0; k < 4; k++) push_exp(base + 5 + k, 3, 'h61 + k);
        tick();
        check("t4_grant1", 32'(grant_id), 32'd1);
        repeat (2) tick();
        #1;
        check("t4_drop_still_own", 32'(grant_active), 32'd1);
        check("t4_drop_no_write", 32'(fifo_write_en), 32'd0);
        tick();
        check("t4_idle_after_drop", 32'(grant_active), 32'd0);
        check("t4_id_holds", 32'(grant_id), 32'd1);
        tick();
        check("t4_grant3", 32'(grant_id), 32'd3);
        check("t4_grant3_active", 32'(grant_active), 32'd1);
        repeat (4) tick();
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // T5: asynchronous reset mid-burst, then arbitration restarts from 0.
        do_reset();
        load(2, 'h81, 6);
        apply();
        base = int'(cyc);
        push_exp(base + 1, 2, 'h81);
        push_exp(base + 2, 2, 'h82);
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        load(1, 'h91, 4);
        apply();
        for (int k = 0; k < 4; k++) push_exp(base + 5 + k, 1, 'h91 + k);
        for (int k = 0; k < 4; k++) push_exp(base + 10 + k, 2, 'h83 + k);
        #1;
        check("t5_async_write_en", 32'(fifo_write_en), 32'd0);
        check("t5_async_ready", 32'(req_ready), 32'd0);
        check("t5_async_grant_active", 32'(grant_active), 32'd0);
        check("t5_async_grant_id", 32'(grant_id), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("t5_first_grant_lowest", 32'(grant_id), 32'd1);
        repeat (5) tick();
        check("t5_second_grant", 32'(grant_id), 32'd2);
        repeat (4) tick();
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Random valid/full: invariants and fairness only.
        do_reset();
        rand_mode = 1'b1;
        repeat (3000) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 9) < 8);
            req_data  = $urandom();
            fifo_full = ($urandom_range(0, 3) == 0);
        end
        req_valid = '0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rand_idle_end", 32'(grant_active), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
